uart_tx_frame: RTL

Parametrised UART transmitter, next generation of the fixed 8N1 serialiser.
- Integrates its own baud divider; no external clk_bps/bps_start pair.
- Accepts words via a valid/ready handshake.
- Supports configurable data width, parity and stop bits.
- Sits between the command/response logic and the rs232_tx pad; one instance per serial channel.

---
 rtl/uart_tx_frame_if.sv | 12 +
 rtl/uart_tx_frame.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Word handshake between a source and uart_tx_frame: data qualified by valid,
// accepted on a rising edge where valid and ready are both high.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with integrated baud divider and valid/ready input.
// Define UART_TX_FIFO_EN to place a 2**FIFO_AW-entry FIFO in front of the serialiser.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  uart_tx_frame_if.slave tx_if,
  output logic           rs232_tx,
  output logic           tx_busy,
  output logic           tx_done
);

  // state    | meaning
  // S_IDLE   | line high, ready for the next word
  // S_START  | start bit (line low)
  // S_DATA   | payload bits, LSB first
  // S_PARITY | parity bit (only when PARITY != 0)
  // S_STOP   | STOP_BITS stop periods (line high)
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || FIFO_AW < 1)
  begin : g_bad_param
    $error("uart_tx_frame: illegal parameter set");
  end

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 line_d;
  logic                 done_d;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;
  logic                 start_req;
  logic [DATA_BITS-1:0] start_word;

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 2**FIFO_AW;

  logic [DATA_BITS-1:0] fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     fifo_cnt;
  logic                 push, pop;

  assign tx_if.tx_ready = (fifo_cnt != (FIFO_AW+1)'(DEPTH)) && !sys_rst;
  assign push           = tx_if.tx_valid && tx_if.tx_ready;
  assign pop            = (state_q == S_IDLE) && (fifo_cnt != '0);
  assign start_req      = pop;
  assign start_word     = fifo_mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= tx_if.tx_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end
`else
  assign tx_if.tx_ready = (state_q == S_IDLE) && !sys_rst;
  assign start_req      = tx_if.tx_valid && tx_if.tx_ready;
  assign start_word     = tx_if.tx_data;
`endif

  assign bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
  assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));
  assign tx_busy   = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    line_d  = 1'b1;
    baud_d  = (state_q == S_IDLE || bit_end) ? '0 : baud_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (start_req) begin
          state_d = S_START;
          shreg_d = start_word;
          par_d   = (PARITY == 1) ? ~^start_word : ^start_word;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (last_data) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The line register is loaded from the next state so the start bit
    // appears in the cycle right after the accepting edge.
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      rs232_tx <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      rs232_tx <= line_d;
      tx_done  <= done_d;
    end
  end

endmodule
